uart_rx_controller: RTL and testbench

//  Sequencing FSM for the UART receive datapath: qualifies start bits, arms/clears the datapath, and collects finished frames.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_controller.sv | 149 ++++++++++++++
 tb/tb_uart_rx_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int BAUD_W_DEF = 12;
    localparam int FIFO_D_DEF = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        RECEIVE   = 3'd2,
        CHECK     = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    // Datapath line select / shift enable for a given state; IDLE follows the enable.
    function automatic logic sel_for(input rx_state_t s, input logic en);
        logic r;
        r = 1'b0;
        case (s)
            IDLE:      r = en;
            START_CHK: r = 1'b1;
            RECEIVE:   r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Datapath clear is held in the quiet states so the baud counter restarts on the falling edge.
    function automatic logic start_for(input rx_state_t s);
        return (s == IDLE) || (s == WAIT_IDLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small circular receive FIFO with wrap-around pointers and an occupancy count.
// Latency: push visible at dout/empty one cycle later; dout is the head combinationally.
// Backpressure: push while full is dropped unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);

    localparam int AW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == ($clog2(D)+1)'(D));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Storage, pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + ($clog2(D)+1)'(1);
                2'b01:   count <= count - ($clog2(D)+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start-bit qualification, frame collection, byte buffering, sticky errors and irq.
// Latency: rx_ready rises one cycle after the CHECK cycle; FSM outputs are registered from next state.
// Backpressure: buffer full at CHECK drops the byte and sets overrun_err unless rd_en pops in that cycle.
// Build option UART_RX_FIFO_EN selects a FIFO_D-entry FIFO instead of a single holding register.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BAUD_W = BAUD_W_DEF,
    parameter int FIFO_D = FIFO_D_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [BAUD_W-1:0] baud_divisor,
    input  logic              start_detected,
    input  logic              rx_done,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              rx_start,
    output logic              rx_sel,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              rx_irq,
    output logic              busy
);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [BAUD_W-1:0] cnt;
    logic [BAUD_W-1:0] half_raw;
    logic [BAUD_W-1:0] half_bit;
    logic              chk_cycle;
    logic              buf_full;
    logic              pop;
    logic              wr;
    logic              ovr_set;
    logic              fe_set;

    // A divisor below 2 would give a zero half-bit; clamp it so START_CHK still samples once.
    assign half_raw = baud_divisor >> 1;
    assign half_bit = (half_raw == '0) ? BAUD_W'(1) : half_raw;

    // Next-state decode; dropping enable aborts any frame back to IDLE.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (start_detected) state_nxt = START_CHK;
                START_CHK: begin
                    if (!start_detected)      state_nxt = IDLE;
                    else if (cnt == half_bit) state_nxt = RECEIVE;
                end
                RECEIVE:   if (rx_done) state_nxt = CHECK;
                CHECK:     state_nxt = WAIT_IDLE;
                WAIT_IDLE: if (!start_detected) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // State, half-bit counter and registered datapath controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rx_start <= 1'b1;
            rx_sel   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == START_CHK && state_nxt == START_CHK) ? cnt + BAUD_W'(1) : '0;
            rx_start <= start_for(state_nxt);
            rx_sel   <= sel_for(state_nxt, enable);
            busy     <= (state_nxt != IDLE);
        end
    end

    // A same-cycle pop frees a slot, so a full buffer accepts the new byte without overrun.
    assign chk_cycle = (state == CHECK) && enable;
    assign pop       = rd_en & rx_ready;
    assign wr        = chk_cycle & data_valid & (~buf_full | pop);
    assign ovr_set   = chk_cycle & data_valid & buf_full & ~pop;
    assign fe_set    = chk_cycle & ~data_valid;

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= fe_set  | (frame_err   & ~err_clr);
            overrun_err <= ovr_set | (overrun_err & ~err_clr);
        end
    end

    assign rx_irq = rx_ready | frame_err | overrun_err;

`ifdef UART_RX_FIFO_EN
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(FIFO_D):0] fifo_count;

    uart_rx_fifo #(
        .W (DATA_W),
        .D (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr),
        .pop   (pop),
        .din   (data_in),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign buf_full = fifo_full;
    assign rx_ready = ~fifo_empty;
`else
    logic              hold_vld;
    logic [DATA_W-1:0] hold_dat;

    // Single holding register; a write in the same cycle as a pop replaces the byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (wr) begin
            hold_vld <= 1'b1;
            hold_dat <= data_in;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign buf_full = hold_vld;
    assign rx_ready = hold_vld;
    assign rx_data  = hold_dat;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed-plus-random bench for uart_rx_controller against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_controller;

    localparam int DATA_W = 8;
    localparam int BAUD_W = 12;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [BAUD_W-1:0] baud_divisor;
    logic              start_detected;
    logic              rx_done;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              rx_start;
    logic              rx_sel;
    logic              rd_en;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              err_clr;
    logic              frame_err;
    logic              overrun_err;
    logic              rx_irq;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;

    always #5 clk = ~clk;

    uart_rx_controller dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .baud_divisor   (baud_divisor),
        .start_detected (start_detected),
        .rx_done        (rx_done),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .rx_start       (rx_start),
        .rx_sel         (rx_sel),
        .rd_en          (rd_en),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .err_clr        (err_clr),
        .frame_err      (frame_err),
        .overrun_err    (overrun_err),
        .rx_irq         (rx_irq),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare buffer/flag outputs against the model.
    task automatic check_model(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(q.size() > 0));
        if (q.size() > 0) chk({tag, "_rx_data"}, 32'(rx_data), 32'(q[0]));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({tag, "_overrun_err"}, 32'(overrun_err), 32'(m_ov));
        chk({tag, "_rx_irq"}, 32'(rx_irq), 32'((q.size() > 0) || m_fe || m_ov));
    endtask

    function automatic int half_of(input int div);
        int h;
        h = div / 2;
        if (h == 0) h = 1;
        return h;
    endfunction

    // Qualify a start bit, then deliver one frame; optional pop / error clear in the CHECK cycle.
    task automatic frame(input logic [7:0] d, input bit good, input bit pop_chk, input bit clr_chk);
        start_detected = 1'b1;
        repeat (half_of(int'(baud_divisor)) + 2) @(negedge clk);
        chk("recv_rx_sel", 32'(rx_sel), 32'd1);
        chk("recv_rx_start", 32'(rx_start), 32'd0);
        start_detected = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rx_done = 1'b1; data_in = d; data_valid = good;
        @(negedge clk);
        rx_done = 1'b0; rd_en = pop_chk; err_clr = clr_chk;
        @(negedge clk);
        rd_en = 1'b0; err_clr = 1'b0; data_valid = 1'b0; data_in = '0;
        if (pop_chk && q.size() > 0) q.delete(0);
        if (clr_chk) begin m_fe = 1'b0; m_ov = 1'b0; end
        if (good) begin
            if (q.size() < CAP) q.push_back(d);
            else m_ov = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
        check_model("frame");
        @(negedge clk);
        chk("frame_end_busy", 32'(busy), 32'd0);
        chk("frame_end_rx_start", 32'(rx_start), 32'd1);
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) q.delete(0);
        check_model("read");
    endtask

    task automatic do_clear();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_fe = 1'b0; m_ov = 1'b0;
        check_model("clear");
    endtask

    initial begin
        logic [7:0] b;
        reset = 1'b0; enable = 1'b1; baud_divisor = 12'd16;
        start_detected = 1'b0; rx_done = 1'b0; data_valid = 1'b0; data_in = '0;
        rd_en = 1'b0; err_clr = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rx_start", 32'(rx_start), 32'd1);
        chk("rst_rx_sel", 32'(rx_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        check_model("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rx_sel", 32'(rx_sel), 32'd1);

        // Glitch: line low for 5 cycles with half-bit 8
        start_detected = 1'b1;
        @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd1);
        chk("glitch_rx_start", 32'(rx_start), 32'd0);
        repeat (4) @(negedge clk);
        start_detected = 1'b0;
        @(negedge clk);
        chk("glitch_end_busy", 32'(busy), 32'd0);
        chk("glitch_end_rx_start", 32'(rx_start), 32'd1);
        check_model("glitch");

        // Good frame, then read it
        frame(8'hA5, 1'b1, 1'b0, 1'b0);
        do_read();

        // Bad parity, then clear; then error coinciding with clear
        frame(8'h3C, 1'b0, 1'b0, 1'b0);
        do_clear();
        frame(8'h3C, 1'b0, 1'b0, 1'b1);
        do_clear();

        // Overrun: one more good frame than the buffer holds
        frame(8'h11, 1'b1, 1'b0, 1'b0);
        frame(8'h22, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= CAP; i++) frame(8'(i * 8'h11), 1'b1, 1'b0, 1'b0);
        do_clear();
        // Write plus pop on a full buffer: no overrun, still full
        frame(8'h77, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i <= CAP; i++) do_read();

        // Abort mid-RECEIVE
        start_detected = 1'b1;
        repeat (half_of(int'(baud_divisor)) + 2) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rx_sel", 32'(rx_sel), 32'd0);
        chk("abort_rx_start", 32'(rx_start), 32'd1);
        start_detected = 1'b0;
        rx_done = 1'b1; data_valid = 1'b1; data_in = 8'h5A;
        @(negedge clk);
        rx_done = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        check_model("abort");
        enable = 1'b1;
        @(negedge clk);

        // Random frames, divisors, reads and clears
        for (int n = 0; n < 20; n++) begin
            baud_divisor = 12'($urandom_range(0, 20));
            b = 8'($urandom);
            frame(b, ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) do_read();
            if ($urandom_range(0, 3) == 0) do_clear();
        end

        // Reset pulse mid-frame with a byte buffered
        baud_divisor = 12'd6;
        frame(8'hC3, 1'b1, 1'b0, 1'b0);
        start_detected = 1'b1;
        repeat (half_of(6) + 2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        q.delete(); m_fe = 1'b0; m_ov = 1'b0;
        chk("midrst_rx_start", 32'(rx_start), 32'd1);
        chk("midrst_rx_sel", 32'(rx_sel), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        check_model("midrst");
        start_detected = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_model("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
